mc_main_ctrl: RTL and testbench

//  Main control FSM of the multicycle MIPS core. Sequences fetch/decode/execute/mem/writeback
//  per instruction from opcode, drives all datapath mux selects and write enables, and emits
//  the 2-bit ALUOp consumed by the ALU control decoder. Adds a memory ready handshake with a

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mc_main_ctrl_if.sv | 35 +++
 rtl/mc_mem_wait_timer.sv | 43 ++++
 rtl/mc_main_ctrl.sv | 155 +++++++++++++++
 tb/tb_mc_main_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and encodings for the multicycle MIPS control path.
//   state_t      main controller FSM states
//   OP_*         instr[31:26] opcodes recognised by the controller
//   ALUOP_*      2-bit ALUOp handed to the ALU control decoder
//   ALUB_*       alu_src_b mux encodings
//   PCSRC_*      pc_src mux encodings
//   is_mem_state states that wait on the memory ready handshake
package mips_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTYPEEX = 4'd7,
    RTYPEWB = 4'd8,
    BEQEX   = 4'd9,
    JEX     = 4'd10,
    ADDIEX  = 4'd11,
    ADDIWB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_B       = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if: bundle between the main controller and the datapath/memory.
//   opcode, mem_ready          datapath -> controller
//   iord .. mem_timeout        controller -> datapath (selects, enables, status pulses)
// Modports: master = controller side, slave = datapath side.
interface mc_main_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       branch;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_write, branch, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_write, branch, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mc_mem_wait_timer.sv
// mc_mem_wait_timer: counts wait cycles of a memory access and flags a timeout.
//   clk, rst_n    clock, async active-low reset
//   in_mem_state  controller is in a state waiting on mem_ready
//   mem_ready     memory completes the access this cycle
//   expire        combinational: limit reached with mem_ready still low
// MEM_TIMEOUT = 0 disables expiry; the counter still runs and saturates.
module mc_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_mem_state,
  input  logic mem_ready,
  output logic expire
);

  localparam int unsigned CW      = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned LIMIT_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT   = LIMIT_I[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit TO_EN = (MEM_TIMEOUT > 0);

  logic [CW-1:0] cnt;

  always_comb begin
    expire = 1'b0;
    if (TO_EN)
      expire = in_mem_state && !mem_ready && (cnt == LIMIT);
  end

  // Leaving a memory state only happens via mem_ready or an abort, so clearing
  // on those (and outside memory states) covers every state change, including
  // the FETCH -> FETCH restart after a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!in_mem_state || mem_ready || expire)
      cnt <= '0;
    else if (cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: main control FSM of the multicycle MIPS core.
//   clk, rst_n  core clock, async active-low reset
//   bus         mc_main_ctrl_if.master: opcode/mem_ready in; mux selects,
//               write enables, alu_op and illegal_op/mem_timeout pulses out
// Parameter MEM_TIMEOUT: max wait cycles on mem_ready (0 = no timeout).
// Macro MC_MAIN_CTRL_ADDI_EN: adds the addi path (ADDIEX -> ADDIWB); without
// it opcode 0x08 is reported as illegal.
module mc_main_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mc_main_ctrl_if.master bus
);

  state_t state, state_nxt;
  logic   expire;
  logic   dec_illegal;
  logic   illegal_q;
  logic   timeout_q;

  mc_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_mem_state (is_mem_state(state)),
    .mem_ready    (bus.mem_ready),
    .expire       (expire)
  );

  always_comb begin
    state_nxt   = state;
    dec_illegal = 1'b0;
    case (state)
      IDLE:   state_nxt = FETCH;
      FETCH:  if (bus.mem_ready) state_nxt = DECODE;
              else if (expire)   state_nxt = FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_J:         state_nxt = JEX;
`ifdef MC_MAIN_CTRL_ADDI_EN
          OP_ADDI:      state_nxt = ADDIEX;
`endif
          default: begin
            state_nxt   = FETCH;
            dec_illegal = 1'b1;
          end
        endcase
      end
      MEMADR:  state_nxt = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (bus.mem_ready) state_nxt = MEMWB;
               else if (expire)   state_nxt = FETCH;
      MEMWB:   state_nxt = FETCH;
      MEMWR:   if (bus.mem_ready || expire) state_nxt = FETCH;
      RTYPEEX: state_nxt = RTYPEWB;
      RTYPEWB: state_nxt = FETCH;
      BEQEX:   state_nxt = FETCH;
      JEX:     state_nxt = FETCH;
`ifdef MC_MAIN_CTRL_ADDI_EN
      ADDIEX:  state_nxt = ADDIWB;
      ADDIWB:  state_nxt = FETCH;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= dec_illegal;
      timeout_q <= expire;
    end
  end

  // Moore decode; only FETCH's ir_write/pc_write look at mem_ready, which also
  // keeps them low on a timed-out fetch.
  always_comb begin
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = ALUB_B;
    bus.alu_op     = ALUOP_ADD;
    bus.pc_src     = PCSRC_ALU;
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ALUB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE:  bus.alu_src_b = ALUB_IMM_SH2;
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUB_IMM;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      RTYPEEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      BEQEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_SUB;
        bus.pc_src    = PCSRC_ALUOUT;
        bus.branch    = 1'b1;
      end
      JEX: begin
        bus.pc_src   = PCSRC_JUMP;
        bus.pc_write = 1'b1;
      end
`ifdef MC_MAIN_CTRL_ADDI_EN
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUB_IMM;
      end
      ADDIWB:  bus.reg_write = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bus.illegal_op  = illegal_q;
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
module tb_mc_main_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_main_ctrl_if bus16 ();
  mc_main_ctrl_if bus4 ();

  mc_main_ctrl #(.MEM_TIMEOUT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  mc_main_ctrl #(.MEM_TIMEOUT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks = 0;
  int errors = 0;
  logic [17:0] sb[$];
  logic [17:0] got, e;

  // {iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  //  alu_src_b[1:0],alu_op[1:0],pc_src[1:0],pc_write,branch,illegal_op,mem_timeout}
  function automatic logic [17:0] exp_out(state_t s, bit rdy, bit ill, bit tmo);
    logic [17:0] v = '0;
    case (s)
      FETCH:   v = {1'b0, 1'b1, 1'b0, rdy, 4'b0000, 2'b01, 2'b00, 2'b00, rdy, 1'b0, 2'b00};
      DECODE:  v = {8'b0000_0000, 2'b11, 2'b00, 2'b00, 4'b0000};
      MEMADR:  v = {8'b0000_0001, 2'b10, 2'b00, 2'b00, 4'b0000};
      MEMRD:   v = {8'b1100_0000, 2'b00, 2'b00, 2'b00, 4'b0000};
      MEMWB:   v = {8'b0000_0110, 2'b00, 2'b00, 2'b00, 4'b0000};
      MEMWR:   v = {8'b1010_0000, 2'b00, 2'b00, 2'b00, 4'b0000};
      RTYPEEX: v = {8'b0000_0001, 2'b00, 2'b10, 2'b00, 4'b0000};
      RTYPEWB: v = {8'b0000_1010, 2'b00, 2'b00, 2'b00, 4'b0000};
      BEQEX:   v = {8'b0000_0001, 2'b00, 2'b01, 2'b01, 4'b0100};
      JEX:     v = {8'b0000_0000, 2'b00, 2'b00, 2'b10, 4'b1000};
      ADDIEX:  v = {8'b0000_0001, 2'b10, 2'b00, 2'b00, 4'b0000};
      ADDIWB:  v = {8'b0000_0010, 2'b00, 2'b00, 2'b00, 4'b0000};
      default: v = '0;
    endcase
    v[1] = ill;
    v[0] = tmo;
    return v;
  endfunction

  function automatic logic [17:0] sample(bit use4);
    if (use4)
      return {bus4.iord, bus4.mem_read, bus4.mem_write, bus4.ir_write, bus4.reg_dst,
              bus4.mem_to_reg, bus4.reg_write, bus4.alu_src_a, bus4.alu_src_b, bus4.alu_op,
              bus4.pc_src, bus4.pc_write, bus4.branch, bus4.illegal_op, bus4.mem_timeout};
    return {bus16.iord, bus16.mem_read, bus16.mem_write, bus16.ir_write, bus16.reg_dst,
            bus16.mem_to_reg, bus16.reg_write, bus16.alu_src_a, bus16.alu_src_b, bus16.alu_op,
            bus16.pc_src, bus16.pc_write, bus16.branch, bus16.illegal_op, bus16.mem_timeout};
  endfunction

  task automatic set_in(input logic [5:0] op, input bit rdy);
    bus16.opcode = op;  bus16.mem_ready = rdy;
    bus4.opcode  = op;  bus4.mem_ready  = rdy;
  endtask

  // Drive one cycle's inputs just after the edge and queue the expected outputs.
  task automatic drive(input logic [5:0] op, input bit rdy, input state_t s,
                       input bit ill, input bit tmo);
    @(posedge clk); #1;
    set_in(op, rdy);
    sb.push_back(exp_out(s, rdy, ill, tmo));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_in(6'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_in(6'h00, 1'b0);
    sb.push_back('0);
    #1; got = sample(0); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_asserted got %h exp %h", got, e); end
    got = sample(1); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_asserted_t4 got %h exp %h", got, e); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back('0);
    #1; got = sample(0); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_idle got %h exp %h", got, e); end
    for (int i = 0; i < 2; i++) begin
      drive(6'h00, 1'b0, FETCH, 1'b0, 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_fetch c%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_lw();
    state_t st [6] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(OP_LW, 1'b1, st[i], 1'b0, 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL lw c%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_rtype();
    state_t st [5] = '{FETCH, DECODE, RTYPEEX, RTYPEWB, FETCH};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(OP_RTYPE, 1'b1, st[i], 1'b0, 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL rtype c%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_beq_j();
    state_t sb_st [4] = '{FETCH, DECODE, BEQEX, FETCH};
    state_t sj_st [4] = '{FETCH, DECODE, JEX, FETCH};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(OP_BEQ, 1'b1, sb_st[i], 1'b0, 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL beq c%0d got %h exp %h", i, got, e); end
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(OP_J, 1'b1, sj_st[i], 1'b0, 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL j c%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_sw_wait();
    state_t st [8] = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, MEMWR, MEMWR, FETCH};
    bit     rd [8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(OP_SW, rd[i], st[i], 1'b0, 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL sw_wait c%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_fetch_timeout();
    bit rd [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    bit to [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(OP_RTYPE, rd[i], FETCH, 1'b0, to[i]);
      #1; got = sample(1); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL fetch_timeout c%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_memrd_timeout();
    state_t st [9] = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMRD, FETCH, FETCH};
    bit     rd [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit     to [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(OP_LW, rd[i], st[i], 1'b0, to[i]);
      #1; got = sample(1); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL memrd_timeout c%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_ready_at_limit();
    state_t st [9] = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMRD, MEMWB, FETCH};
    bit     rd [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(OP_LW, rd[i], st[i], 1'b0, 1'b0);
      #1; got = sample(1); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL ready_at_limit c%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_illegal();
    state_t st [4] = '{FETCH, DECODE, FETCH, FETCH};
    bit     rd [4] = '{1, 0, 0, 0};
    bit     il [4] = '{0, 0, 1, 0};
`ifdef MC_MAIN_CTRL_ADDI_EN
    state_t sa [5] = '{FETCH, DECODE, ADDIEX, ADDIWB, FETCH};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(6'h3F, rd[i], st[i], il[i], 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL illegal_3f c%0d got %h exp %h", i, got, e); end
    end
    do_reset();
`ifdef MC_MAIN_CTRL_ADDI_EN
    for (int i = 0; i < 5; i++) begin
      drive(OP_ADDI, 1'b1, sa[i], 1'b0, 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL addi c%0d got %h exp %h", i, got, e); end
    end
`else
    for (int i = 0; i < 4; i++) begin
      drive(OP_ADDI, rd[i], st[i], il[i], 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL illegal_08 c%0d got %h exp %h", i, got, e); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    state_t st [4] = '{FETCH, DECODE, MEMADR, MEMRD};
    bit     rd [4] = '{1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(OP_LW, rd[i], st[i], 1'b0, 1'b0);
      #1; got = sample(0); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_mid c%0d got %h exp %h", i, got, e); end
    end
    rst_n = 1'b0;
    sb.push_back('0);
    #1; got = sample(0); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_mid_drop got %h exp %h", got, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('0);
    #1; got = sample(0); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_mid_idle got %h exp %h", got, e); end
  endtask

  initial begin
    set_in(6'h00, 1'b0);
    test_reset();
    test_lw();
    test_rtype();
    test_beq_j();
    test_sw_wait();
    test_fetch_timeout();
    test_memrd_timeout();
    test_ready_at_limit();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
